// File: rtl/alu_operand_issue.sv
// Operand issue stage for the saturating ADD/SUB unit: register file, RAW/WAW scoreboard,
// writeback forwarding and a registered valid/ready operand bundle. Optional ALU_ISSUE_PERF_EN.
module alu_operand_issue #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned REG_CNT = 8,
    parameter int unsigned ADDR_W  = 3
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              instr_valid_in,
    output logic              instr_ready_out,
    input  logic              instr_sub_in,
    input  logic [ADDR_W-1:0] instr_rs_in,
    input  logic [ADDR_W-1:0] instr_rt_in,
    input  logic [ADDR_W-1:0] instr_rd_in,
    input  logic              instr_imm_sel_in,
    input  logic [DATA_W-1:0] instr_imm_in,
    input  logic              wb_valid_in,
    input  logic [ADDR_W-1:0] wb_rd_in,
    input  logic [DATA_W-1:0] wb_data_in,
    output logic              iss_valid_out,
    input  logic              iss_ready_in,
    output logic              iss_sub_out,
    output logic [DATA_W-1:0] iss_a_out,
    output logic [DATA_W-1:0] iss_b_out,
    output logic [ADDR_W-1:0] iss_rd_out,
    output logic [15:0]       stall_cnt_out
);

    logic [DATA_W-1:0]  regfile_q [REG_CNT];
    logic [REG_CNT-1:0] pending_q, pending_d;

    logic              iss_valid_q, iss_sub_q;
    logic [DATA_W-1:0] iss_a_q, iss_b_q;
    logic [ADDR_W-1:0] iss_rd_q;

    logic              slot_free, hazard, accept, wb_write;
    logic              hz_rs, hz_rt, hz_rd;
    logic [DATA_W-1:0] opnd_a, opnd_b;

    // A source is only blocked if its pending write is not being resolved this very cycle.
    function automatic logic src_hz(input logic [ADDR_W-1:0]  r,
                                    input logic [REG_CNT-1:0] pend,
                                    input logic               wv,
                                    input logic [ADDR_W-1:0]  wr);
        return (r != '0) && pend[r] && !(wv && (wr == r));
    endfunction

    always_comb begin
        hz_rs = src_hz(instr_rs_in, pending_q, wb_valid_in, wb_rd_in);
        hz_rt = !instr_imm_sel_in && src_hz(instr_rt_in, pending_q, wb_valid_in, wb_rd_in);
        hz_rd = src_hz(instr_rd_in, pending_q, wb_valid_in, wb_rd_in);
    end

    assign slot_free       = !iss_valid_q || iss_ready_in;
    assign hazard          = hz_rs || hz_rt || hz_rd;
    assign instr_ready_out = slot_free && !hazard;
    assign accept          = instr_valid_in && instr_ready_out;
    assign wb_write        = wb_valid_in && (wb_rd_in != '0);

    always_comb begin
        opnd_a = regfile_q[instr_rs_in];
        if (instr_rs_in == '0) begin
            opnd_a = '0;
        end else if (wb_valid_in && (wb_rd_in == instr_rs_in)) begin
            opnd_a = wb_data_in;
        end

        opnd_b = regfile_q[instr_rt_in];
        if (instr_imm_sel_in) begin
            opnd_b = instr_imm_in;
        end else if (instr_rt_in == '0) begin
            opnd_b = '0;
        end else if (wb_valid_in && (wb_rd_in == instr_rt_in)) begin
            opnd_b = wb_data_in;
        end
    end

    // Clear before set so a same-cycle accept to the written register keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (wb_write) begin
            pending_d[wb_rd_in] = 1'b0;
        end
        if (accept && (instr_rd_in != '0)) begin
            pending_d[instr_rd_in] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < int'(REG_CNT); i++) begin
                regfile_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            if (wb_write) begin
                regfile_q[wb_rd_in] <= wb_data_in;
            end
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            iss_valid_q <= 1'b0;
            iss_sub_q   <= 1'b0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_rd_q    <= '0;
        end else if (accept) begin
            iss_valid_q <= 1'b1;
            iss_sub_q   <= instr_sub_in;
            iss_a_q     <= opnd_a;
            iss_b_q     <= opnd_b;
            iss_rd_q    <= instr_rd_in;
        end else if (iss_ready_in) begin
            iss_valid_q <= 1'b0;
        end
    end

    assign iss_valid_out = iss_valid_q;
    assign iss_sub_out   = iss_sub_q;
    assign iss_a_out     = iss_a_q;
    assign iss_b_out     = iss_b_q;
    assign iss_rd_out    = iss_rd_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stall_cnt_q <= '0;
        end else if (instr_valid_in && slot_free && hazard && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_out = stall_cnt_q;
`else
    assign stall_cnt_out = '0;
`endif

endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue: directed scenarios plus randomized traffic against an
// array-based architectural model of the issue stage.
module tb_alu_operand_issue;

    localparam int DW = 16;
    localparam int RC = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid, instr_ready, instr_sub, imm_sel;
    logic [AW-1:0] rs, rt, rd;
    logic [DW-1:0] imm;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          iss_valid, iss_ready, iss_sub;
    logic [DW-1:0] iss_a, iss_b;
    logic [AW-1:0] iss_rd;
    logic [15:0]   stall_cnt;

    always #5 clk = ~clk;

    alu_operand_issue #(.DATA_W(DW), .REG_CNT(RC), .ADDR_W(AW)) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .instr_valid_in  (instr_valid),
        .instr_ready_out (instr_ready),
        .instr_sub_in    (instr_sub),
        .instr_rs_in     (rs),
        .instr_rt_in     (rt),
        .instr_rd_in     (rd),
        .instr_imm_sel_in(imm_sel),
        .instr_imm_in    (imm),
        .wb_valid_in     (wb_valid),
        .wb_rd_in        (wb_rd),
        .wb_data_in      (wb_data),
        .iss_valid_out   (iss_valid),
        .iss_ready_in    (iss_ready),
        .iss_sub_out     (iss_sub),
        .iss_a_out       (iss_a),
        .iss_b_out       (iss_b),
        .iss_rd_out      (iss_rd),
        .stall_cnt_out   (stall_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Architectural model: register values, outstanding writes, the bundle in the slot.
    logic [DW-1:0] m_reg [RC];
    bit            m_pend [RC];
    logic          m_valid, m_sub;
    logic [DW-1:0] m_a, m_b;
    logic [AW-1:0] m_rd;
    int            m_stall;

    function automatic bit m_hz(input logic [AW-1:0] r);
        return (r != 0) && m_pend[r] && !(wb_valid && wb_rd == r);
    endfunction

    function automatic bit m_ready();
        bit hz;
        hz = m_hz(rs) || (!imm_sel && m_hz(rt)) || m_hz(rd);
        return (!m_valid || iss_ready) && !hz;
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] r);
        if (r == 0) return '0;
        if (wb_valid && wb_rd == r) return wb_data;
        return m_reg[r];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < RC; i++) begin
            m_reg[i] = '0;
            m_pend[i] = 0;
        end
        m_valid = 0; m_sub = 0; m_a = '0; m_b = '0; m_rd = '0; m_stall = 0;
    endtask

    task automatic idle();
        instr_valid = 0; instr_sub = 0; rs = '0; rt = '0; rd = '0; imm_sel = 0; imm = '0;
        wb_valid = 0; wb_rd = '0; wb_data = '0; iss_ready = 1;
    endtask

    task automatic set_instr(input bit sub, input int a, input int b, input int d,
                             input bit isel, input logic [DW-1:0] immv);
        instr_valid = 1; instr_sub = sub; rs = AW'(a); rt = AW'(b); rd = AW'(d);
        imm_sel = isel; imm = immv;
    endtask

    task automatic set_wb(input bit v, input int r, input logic [DW-1:0] d);
        wb_valid = v; wb_rd = AW'(r); wb_data = d;
    endtask

    // Advance one clock; the model consumes the inputs held across the edge.
    task automatic tick();
        bit free, acc, stalled;
        logic [DW-1:0] na, nb;
        free = !m_valid || iss_ready;
        acc = instr_valid && m_ready();
        stalled = instr_valid && free && !m_ready();
        na = m_read(rs);
        nb = imm_sel ? imm : m_read(rt);
        @(posedge clk);
        if (wb_valid && wb_rd != 0) begin
            m_reg[wb_rd] = wb_data;
            m_pend[wb_rd] = 0;
        end
        if (acc && rd != 0) m_pend[rd] = 1;
        if (acc) begin
            m_valid = 1; m_sub = instr_sub; m_a = na; m_b = nb; m_rd = rd;
        end else if (iss_ready) begin
            m_valid = 0;
        end
`ifdef ALU_ISSUE_PERF_EN
        if (stalled && m_stall < 65535) m_stall++;
`else
        if (stalled) m_stall = m_stall;
`endif
        #1;
    endtask

    task automatic test_reset();
        logic [36:0] got;
        idle();
        rst_n = 0;
        #1;
        m_reset();
        got = {iss_valid, iss_sub, iss_a, iss_b, iss_rd};
        checks++;
        if (got !== 37'd0) begin
            failures++;
            $display("FAIL reset_bundle got=%h exp=0", got);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_stall got=%h exp=0", stall_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_basic();
        logic [36:0] got;
        set_wb(1, 1, 16'd100); tick();
        set_wb(1, 2, 16'hFFFB); tick();
        set_wb(0, 0, '0);
        set_instr(0, 1, 2, 3, 0, '0);
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready got=%b exp=1", instr_ready);
        end
        tick();
        instr_valid = 0;
        got = {iss_valid, iss_sub, iss_a, iss_b, iss_rd};
        checks++;
        if (got !== {1'b1, 1'b0, 16'd100, 16'hFFFB, 3'd3}) begin
            failures++;
            $display("FAIL basic_bundle got=%h exp=%h", got,
                     {1'b1, 1'b0, 16'd100, 16'hFFFB, 3'd3});
        end
    endtask

    task automatic test_raw_forward();
        logic [36:0] got;
        set_instr(1, 3, 1, 4, 0, '0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (instr_ready !== 1'b0) begin
                failures++;
                $display("FAIL raw_stall cyc=%0d got=%b exp=0", i, instr_ready);
            end
            tick();
        end
        set_wb(1, 3, 16'd95);
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL raw_wb_ready got=%b exp=1", instr_ready);
        end
        tick();
        set_wb(0, 0, '0);
        instr_valid = 0;
        got = {iss_valid, iss_sub, iss_a, iss_b, iss_rd};
        checks++;
        if (got !== {1'b1, 1'b1, 16'd95, 16'd100, 3'd4}) begin
            failures++;
            $display("FAIL raw_forward got=%h exp=%h", got, {1'b1, 1'b1, 16'd95, 16'd100, 3'd4});
        end
    endtask

    task automatic test_hold();
        logic [36:0] got;
        iss_ready = 0;
        set_instr(0, 1, 2, 5, 0, '0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (instr_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_ready cyc=%0d got=%b exp=0", i, instr_ready);
            end
            tick();
            got = {iss_valid, iss_sub, iss_a, iss_b, iss_rd};
            checks++;
            if (got !== {1'b1, 1'b1, 16'd95, 16'd100, 3'd4}) begin
                failures++;
                $display("FAIL hold_bundle cyc=%0d got=%h exp=%h", i, got,
                         {1'b1, 1'b1, 16'd95, 16'd100, 3'd4});
            end
        end
        iss_ready = 1;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_ready got=%b exp=1", instr_ready);
        end
        tick();
        instr_valid = 0;
        got = {iss_valid, iss_sub, iss_a, iss_b, iss_rd};
        checks++;
        if (got !== {1'b1, 1'b0, 16'd100, 16'hFFFB, 3'd5}) begin
            failures++;
            $display("FAIL release_bundle got=%h exp=%h", got,
                     {1'b1, 1'b0, 16'd100, 16'hFFFB, 3'd5});
        end
    endtask

    task automatic test_r0_imm();
        logic [36:0] got;
        // rt=r4 is still pending but must be ignored under imm_sel.
        set_instr(1, 0, 4, 6, 1, 16'h7FFF);
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL imm_ready got=%b exp=1", instr_ready);
        end
        tick();
        got = {iss_valid, iss_sub, iss_a, iss_b, iss_rd};
        checks++;
        if (got !== {1'b1, 1'b1, 16'd0, 16'h7FFF, 3'd6}) begin
            failures++;
            $display("FAIL imm_bundle got=%h exp=%h", got, {1'b1, 1'b1, 16'd0, 16'h7FFF, 3'd6});
        end
        set_instr(0, 0, 0, 7, 0, '0);
        set_wb(1, 0, 16'h1234);
        tick();
        set_wb(0, 0, '0);
        got = {iss_valid, iss_sub, iss_a, iss_b, iss_rd};
        checks++;
        if (got !== {1'b1, 1'b0, 16'd0, 16'd0, 3'd7}) begin
            failures++;
            $display("FAIL r0_fwd got=%h exp=%h", got, {1'b1, 1'b0, 16'd0, 16'd0, 3'd7});
        end
        set_instr(0, 0, 0, 2, 0, '0);
        tick();
        instr_valid = 0;
        got = {iss_valid, iss_sub, iss_a, iss_b, iss_rd};
        checks++;
        if (got !== {1'b1, 1'b0, 16'd0, 16'd0, 3'd2}) begin
            failures++;
            $display("FAIL r0_read got=%h exp=%h", got, {1'b1, 1'b0, 16'd0, 16'd0, 3'd2});
        end
    endtask

    task automatic test_set_wins();
        set_instr(0, 1, 1, 5, 0, '0);
        set_wb(1, 5, 16'd55);
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL setwin_accept got=%b exp=1", instr_ready);
        end
        tick();
        set_wb(0, 0, '0);
        set_instr(0, 5, 0, 1, 0, '0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (instr_ready !== 1'b0) begin
                failures++;
                $display("FAIL setwin_stall cyc=%0d got=%b exp=0", i, instr_ready);
            end
            tick();
        end
        set_wb(1, 5, 16'd7);
        tick();
        set_wb(0, 0, '0);
        instr_valid = 0;
        checks++;
        if ({iss_valid, iss_a, iss_rd} !== {1'b1, 16'd7, 3'd1}) begin
            failures++;
            $display("FAIL setwin_bundle got=%h exp=%h", {iss_valid, iss_a, iss_rd},
                     {1'b1, 16'd7, 3'd1});
        end
    endtask

    task automatic test_random();
        logic [52:0] got, exp;
        for (int n = 0; n < 400; n++) begin
            instr_valid = ($urandom % 4) != 0;
            instr_sub = 1'($urandom);
            rs = AW'($urandom); rt = AW'($urandom); rd = AW'($urandom);
            imm_sel = ($urandom % 3) == 0;
            imm = DW'($urandom);
            iss_ready = ($urandom % 4) != 0;
            wb_valid = ($urandom % 2) != 0;
            wb_rd = AW'($urandom);
            wb_data = DW'($urandom);
            #1;
            checks++;
            if (instr_ready !== m_ready()) begin
                failures++;
                $display("FAIL rand_ready n=%0d got=%b exp=%b", n, instr_ready, m_ready());
            end
            tick();
            got = {iss_valid, iss_sub, iss_a, iss_b, iss_rd, stall_cnt};
            exp = {m_valid, m_sub, m_a, m_b, m_rd, 16'(m_stall)};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL rand_bundle n=%0d got=%h exp=%h", n, got, exp);
            end
        end
    endtask

    task automatic test_after_reset();
        // Registers that were pending before reset must be free and read as zero.
        set_instr(0, 5, 4, 6, 0, '0);
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_ready got=%b exp=1", instr_ready);
        end
        tick();
        instr_valid = 0;
        checks++;
        if ({iss_valid, iss_a, iss_b, iss_rd} !== {1'b1, 16'd0, 16'd0, 3'd6}) begin
            failures++;
            $display("FAIL post_reset_bundle got=%h exp=%h", {iss_valid, iss_a, iss_b, iss_rd},
                     {1'b1, 16'd0, 16'd0, 3'd6});
        end
    endtask

    task automatic test_stall_cnt();
        int n;
        set_instr(0, 0, 0, 1, 0, '0);
        tick();
        set_instr(0, 1, 0, 2, 0, '0);
`ifdef ALU_ISSUE_PERF_EN
        n = 70000;
`else
        n = 40;
`endif
        for (int i = 0; i < n; i++) tick();
        checks++;
        if (stall_cnt !== 16'(m_stall)) begin
            failures++;
            $display("FAIL stall_cnt got=%h exp=%h", stall_cnt, 16'(m_stall));
        end
`ifdef ALU_ISSUE_PERF_EN
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL stall_sat got=%h exp=ffff", stall_cnt);
        end
`else
        checks++;
        if (stall_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL stall_off got=%h exp=0", stall_cnt);
        end
`endif
        idle();
    endtask

    initial begin
        idle();
        m_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_raw_forward();
        test_hold();
        test_r0_imm();
        test_set_wins();
        test_random();
        test_reset();
        test_after_reset();
        test_stall_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_operand_issue.md
Name: alu_operand_issue

Overview:
Issue stage directly upstream of the shared saturating ADD/SUB unit in the custom CPU. Accepts decoded ALU instructions and reads operands from an internal register file. Holds instructions on read-after-write hazards using a per-register pending scoreboard, with writeback forwarding. Presents a registered, valid/ready-handshaked operand bundle (select, a, b, destination) to the execute stage.

Parameters:
DATA_W, 16, operand/register width (signed two's complement)
REG_CNT, 8, number of architectural registers; r0 reads as zero and is never written
ADDR_W, 3, register index width; must equal clog2(REG_CNT)

Ports:
clk_in  in  1  clock, all state updates on rising edge
rst_n_in  in  1  asynchronous active-low reset
instr_valid_in  in  1  instruction offered
instr_ready_out  out  1  instruction accepted this cycle when high with instr_valid_in
instr_sub_in  in  1  0=ADD, 1=SUB
instr_rs_in  in  ADDR_W  source A register
instr_rt_in  in  ADDR_W  source B register (ignored when instr_imm_sel_in=1)
instr_rd_in  in  ADDR_W  destination register
instr_imm_sel_in  in  1  1: B operand = instr_imm_in
instr_imm_in  in  DATA_W  immediate
wb_valid_in  in  1  writeback strobe from downstream
wb_rd_in  in  ADDR_W  writeback destination
wb_data_in  in  DATA_W  writeback value (already saturated)
iss_valid_out  out  1  operand bundle valid
iss_ready_in  in  1  execute stage accepts bundle
iss_sub_out  out  1  drives execute ADD/SUB select
iss_a_out  out  DATA_W  operand A
iss_b_out  out  DATA_W  operand B
iss_rd_out  out  ADDR_W  destination carried to writeback
stall_cnt_out  out  16  hazard stall cycle count (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): all registers r1..rN-1 = 0, pending bits = 0, iss_valid_out=0, iss_sub_out=0, iss_a_out=0, iss_b_out=0, iss_rd_out=0, stall_cnt_out=0.
- Output slot free: slot_free = !iss_valid_out || iss_ready_in.
- Hazard: src_hz(r) = r!=0 && pending[r] && !(wb_valid_in && wb_rd_in==r). hazard = src_hz(rs) || (!imm_sel && src_hz(rt)) || src_hz(rd) (WAW stall).
- instr_ready_out = slot_free && !hazard. Combinational from instr_* and wb_*; no dependency on instr_valid_in.
- Accept (instr_valid_in && instr_ready_out): next edge loads the output register. iss_valid_out=1, iss_sub_out=instr_sub_in, iss_rd_out=instr_rd_in.
- Operand read on accept: r0 -> 0; wb_valid_in && wb_rd_in==r && r!=0 -> wb_data_in (forward); else regfile[r]. B uses instr_imm_in when imm_sel.
- Latency: accept at edge N -> bundle visible after edge N. Back-to-back issue every cycle when independent and iss_ready_in=1.
- Hold: iss_valid_out && !iss_ready_in -> all iss_* outputs stable.
- Drain: iss_ready_in && no accept -> iss_valid_out=0; data outputs retain last value.
- Writeback: wb_valid_in && wb_rd_in!=0 -> regfile[wb_rd_in]=wb_data_in, pending[wb_rd_in] cleared. Writes to r0 are dropped.
- Set on accept with rd!=0: pending[rd] set. Same-cycle set and clear of the same register: set wins.
- Reset mid-operation: in-flight bundle and pending bits are discarded; the downstream stage is reset by the same rst_n_in.

Optional Feature:
Macro ALU_ISSUE_PERF_EN.
- Defined: stall_cnt_out increments each cycle with instr_valid_in && slot_free && hazard; saturates at 16'hFFFF and never wraps.
- Undefined: stall_cnt_out tied to 0; no counter logic.

Test Plan:
- Reset then wb r1=100, r2=-5 -> issue ADD rd=r3 rs=r1 rt=r2 -> next cycle iss_a_out=100, iss_b_out=-5 (0xFFFB), iss_sub_out=0, iss_rd_out=3.
- Issue r3=r1+r2 then r4=r3-r1 back-to-back with iss_ready_in=1 -> second instruction has instr_ready_out=0 until wb r3. On the wb cycle it is accepted with iss_a_out=forwarded wb_data_in (95).
- iss_ready_in=0 for 3 cycles with a bundle valid -> iss_* unchanged, instr_ready_out=0. Release -> bundle consumed, next instruction issues the following cycle.
- rs=r0, imm_sel=1, imm=16'h7FFF, SUB -> iss_a_out=0, iss_b_out=32767, iss_sub_out=1. wb to r0 with 0x1234 -> r0 still reads 0.
- Same-cycle accept rd=r5 and wb r5 -> pending[r5] stays 1; next instruction reading r5 stalls until a later wb r5.
- With ALU_ISSUE_PERF_EN: hold a hazard for 70000 cycles -> stall_cnt_out=16'hFFFF. Without the macro -> stall_cnt_out=0.
